// File: rtl/wait_cmd_sequencer.sv
// Command FIFO plus issue/wait/respond sequencer in front of wait_event.
// Commands are issued one at a time; each returns a status/elapsed-cycles response.
module wait_cmd_sequencer #(
    parameter int WAIT_SIZE    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int GUARD_CYCLES = 16,
    parameter int IDX_W        = ($clog2(WAIT_SIZE + 1) > 1) ? $clog2(WAIT_SIZE + 1) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic [IDX_W-1:0]              i_cmd_idx,
    input  logic                          i_cmd_wtf,
    input  logic [31:0]                   i_cmd_timeout,
    output logic                          o_en_wait_event,
    output logic [31:0]                   o_wait_en,
    output logic                          o_sel_wtr_wtf,
    output logic [31:0]                   o_max_timeout,
    input  logic                          i_wait_done,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [1:0]                    o_rsp_status,
    output logic [31:0]                   o_rsp_cycles,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = IDX_W + 1 + 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t               state;
    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 push;
    logic                 pop;
    logic [IDX_W-1:0]     head_idx;
    logic                 head_wtf;
    logic [31:0]          head_timeout;
    logic                 done_q;
    logic                 done_rise;
    logic [31:0]          cycle_cnt;
    logic                 guard_hit;

    assign o_cmd_ready  = (count < CNT_W'(FIFO_DEPTH));
    assign push         = i_cmd_valid & o_cmd_ready;
    assign pop          = (state == ST_IDLE) && (count != '0);
    assign o_fifo_count = count;
    assign o_busy       = (state != ST_IDLE) || (count != '0);

    assign {head_idx, head_wtf, head_timeout} = mem[rd_ptr];

    assign done_rise = i_wait_done & ~done_q;
    // 33-bit sum so a large timeout cannot wrap the guard threshold
    assign guard_hit = {1'b0, cycle_cnt} >= ({1'b0, o_max_timeout} + 33'(GUARD_CYCLES));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_cmd_idx, i_cmd_wtf, i_cmd_timeout};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= i_wait_done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            o_en_wait_event <= 1'b0;
            o_wait_en       <= '0;
            o_sel_wtr_wtf   <= 1'b0;
            o_max_timeout   <= '0;
            o_rsp_valid     <= 1'b0;
            o_rsp_status    <= '0;
            o_rsp_cycles    <= '0;
            cycle_cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        o_wait_en     <= 32'(head_idx);
                        o_sel_wtr_wtf <= head_wtf;
                        o_max_timeout <= head_timeout;
                        if (32'(head_idx) >= 32'(WAIT_SIZE)) begin
                            o_rsp_valid  <= 1'b1;
                            o_rsp_status <= 2'b10;
                            o_rsp_cycles <= '0;
                            state        <= ST_RESP;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    o_en_wait_event <= 1'b1;
                    cycle_cnt       <= '0;
                    state           <= ST_WAIT;
                end
                ST_WAIT: begin
                    o_en_wait_event <= 1'b0;
                    if (done_rise) begin
                        o_rsp_valid  <= 1'b1;
                        o_rsp_status <= 2'b00;
                        o_rsp_cycles <= cycle_cnt;
                        state        <= ST_RESP;
                    end else if (guard_hit) begin
                        o_rsp_valid  <= 1'b1;
                        o_rsp_status <= 2'b01;
                        o_rsp_cycles <= cycle_cnt;
                        state        <= ST_RESP;
                    end else if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + 32'd1;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
